// File: rtl/pla_rsearch_if.sv
// PLA access port seen from the search engine (master) and the PLA (slave).
// Carries the address, the clock enable and the registered PLA output word.
interface pla_rsearch_if #(
  parameter int AW = 6,
  parameter int DW = 48
);
  logic [AW-1:0] PLA_A;
  logic          PLA_CE;
  logic [DW-1:0] PLA_Q;

  modport master (output PLA_A, output PLA_CE, input  PLA_Q);
  modport slave  (input  PLA_A, input  PLA_CE, output PLA_Q);
endinterface

// File: rtl/pla_rsearch.sv
// pla_rsearch: scans every PLA input code and reports the lowest address whose output matches Target under Mask.
// Build option: define PLA_RSEARCH_COUNT_ALL_EN to scan all codes and count every match instead of stopping at the first.
module pla_rsearch #(
  parameter int AW  = 6,
  parameter int DW  = 48,
  parameter int LAT = 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Start_i,
  input  logic [DW-1:0] Target_i,
  input  logic [DW-1:0] Mask_i,
  output logic          Busy_o,
  output logic          Done_o,
  output logic          Found_o,
  output logic [AW-1:0] Addr_o,
  output logic [AW:0]   Count_o,
  pla_rsearch_if.master pla
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_e;

  // Every tag stage except the one being compared this cycle.
  localparam logic [LAT-1:0] UPSTREAM = {LAT{1'b1}} >> 1;
`ifdef PLA_RSEARCH_COUNT_ALL_EN
  localparam logic [AW:0] CNT_MAX = (AW+1)'(1 << AW);
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] pla_a_q, pla_a_d;
  logic          ce_q, ce_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          found_q, found_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] target_q, target_d;
  logic [DW-1:0] mask_q, mask_d;
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [AW-1:0]  tag_addr_q [LAT];
  logic [AW-1:0]  tag_addr_d [LAT];
  logic           push;
  logic           hit;

  assign hit = ((state_q == S_SCAN) || (state_q == S_DRAIN)) && tag_vld_q[LAT-1] &&
               (((pla.PLA_Q ^ target_q) & mask_q) == '0);

  always_comb begin
    // NOTE: every next-state value gets its hold value first, so no path through this block can infer a latch.
    state_d  = state_q;
    pla_a_d  = pla_a_q;
    ce_d     = ce_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    addr_d   = addr_q;
    count_d  = count_q;
    target_d = target_q;
    mask_d   = mask_q;
    push     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (Start_i) begin
          target_d = Target_i;
          mask_d   = Mask_i;
          found_d  = 1'b0;
          addr_d   = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          ce_d     = 1'b1;
          pla_a_d  = '0;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        push    = 1'b1;
        pla_a_d = pla_a_q + AW'(1);
        if (pla_a_q == '1) begin
          ce_d    = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((tag_vld_q & UPSTREAM) == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    tag_vld_d[0]  = push;
    tag_addr_d[0] = pla_a_q;
    for (int i = 1; i < LAT; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_addr_d[i] = tag_addr_q[i-1];
    end

    if (hit) begin
      found_d = 1'b1;
      if (!found_q) addr_d = tag_addr_q[LAT-1];
`ifdef PLA_RSEARCH_COUNT_ALL_EN
      if (count_q != CNT_MAX) count_d = count_q + (AW+1)'(1);
`else
      // First match ends the search; results still in flight are dropped.
      count_d   = (AW+1)'(1);
      tag_vld_d = '0;
      ce_d      = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      state_d   = S_DONE;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      pla_a_q   <= '0;
      ce_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      addr_q    <= '0;
      count_q   <= '0;
      tag_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      pla_a_q   <= pla_a_d;
      ce_q      <= ce_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      found_q   <= found_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      tag_vld_q <= tag_vld_d;
    end
  end

  // NOTE: data-only storage is left unreset; the valid bits and the FSM decide when it is looked at.
  always_ff @(posedge Clk) begin
    target_q   <= target_d;
    mask_q     <= mask_d;
    tag_addr_q <= tag_addr_d;
  end

  assign Busy_o     = busy_q;
  assign Done_o     = done_q;
  assign Found_o    = found_q;
  assign Addr_o     = addr_q;
  assign Count_o    = count_q;
  assign pla.PLA_A  = pla_a_q;
  assign pla.PLA_CE = ce_q;

endmodule

// File: doc/pla_rsearch.md
# pla_rsearch

Reverse-lookup engine for the registered 6-in/48-out microcode PLA: given a target control word and a care mask, it drives the PLA address port through every input code and reports which address produces a matching output. It sits on the initiator side of the PLA's A/CE/Q interface. It serves microcode validation, opcode-from-control-word recovery and self-test.

## Interface
- AW, 6, PLA address width; the block scans 2^AW codes.
- DW, 48, PLA output width.
- LAT, 1, PLA output latency in clock cycles (1 to 4).
- Clk  in  1  clock; all logic on posedge.
- Rst  in  1  reset, synchronous, active-high.
- Start  in  1  begin a search; sampled only while Busy=0.
- Target  in  DW  desired control word; captured on the Start edge.
- Mask  in  DW  care bits (1 = compare); captured on the Start edge.
- Busy  out  1  search in progress.
- Done  out  1  one-cycle pulse marking the end of a search.
- Found  out  1  at least one match; valid from Done until the next Start.
- Addr  out  AW  lowest matching address; 0 when Found=0.
- Count  out  AW+1  number of matches (see Configuration).
- PLA_A  out  AW  PLA address.
- PLA_CE  out  1  PLA clock enable; high only while issuing.
- PLA_Q  in  DW  PLA registered output.

## Operation
- Reset values:
  - All outputs 0 (Busy, Done, Found, Addr, Count, PLA_A, PLA_CE).
  - FSM in IDLE; tag pipeline cleared.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: when Start=1, capture Target and Mask, clear Found/Addr/Count, set Busy=1 and PLA_CE=1 with PLA_A=0, then go to SCAN.
- SCAN:
  - Each cycle, issue the current PLA_A and push {valid, addr} into a LAT-deep tag shift register.
  - Increment PLA_A.
  - After issuing 2^AW−1, go to DRAIN with PLA_CE=0.
- Compare: when the tag output is valid, a match is ((PLA_Q ^ Target) & Mask) == 0.
  - First match sets Found=1 and Addr=tag addr.
  - Later matches leave Addr unchanged.
  - Each match increments Count, saturating at 2^AW.
- DRAIN: go to DONE once the tag pipeline is empty.
- DONE:
  - Done=1 for exactly one cycle and Busy=0, both registered on the same edge.
  - Then return to IDLE.
- Early abort (macro absent): a match during SCAN or DRAIN ends the search on that edge.
  - PLA_CE drops to 0 and the tag pipeline is flushed; in-flight results are discarded.
  - The FSM goes straight to DONE.
- Start while Busy=1 is ignored. Target and Mask changes mid-search have no effect.
- Rst mid-search: everything returns to reset values on that edge and the partial result is lost.
- PLA_A wraps to 0 after the last issue. It holds its value while IDLE.

## Timing
- Let E0 be the edge that samples Start. PLA_A=k is driven in the cycle after edge Ek.
- The result for address k is compared in the cycle after edge E(k+LAT).
- First-match mode, match at address k: Done, Found and Addr are visible after edge E(k+LAT+1).
- No match, or COUNT_ALL_EN build: Done is visible after edge E(2^AW+LAT); with defaults this is E65.
- The next Start is accepted in the cycle Done is high. Back-to-back searches have no idle gap.

## Configuration
- PLA_RSEARCH_COUNT_ALL_EN defined:
  - No early abort; every address is scanned.
  - Count = total matches, 0 to 2^AW.
  - Addr = lowest match.
- Macro absent:
  - Search stops at the first match.
  - Count reads 1 if Found=1, else 0.
  - The count saturation logic is not built.

## Test plan
Bench instantiates the team's 6-to-48 registered PLA with LAT=1.
- Target=48'h2, Mask=48'h2 -> Found=1, Addr=42, Done after E44; with COUNT_ALL_EN: Count=1, Done after E65.
- Target=48'h800, Mask=48'h800 (bit 11) -> Found=1, Addr=48.
- Target bit 47 set, Mask=48'h8000_0000_0000 -> Found=0, Addr=0, Count=0, Done after E65.
- Mask=0 -> first-match build: Found=1, Addr=0, Done after E2; COUNT_ALL_EN build: Count=64.
- Target bit 40 set, Mask bit 40 only, COUNT_ALL_EN -> Found=1, Addr=48, Count=16.
- Assert Rst at E10 mid-scan -> all outputs 0 after that edge, no Done pulse; a fresh Start then completes normally. A Start pulsed during Busy is ignored.
